// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the M-extension execute unit.
//   state_e      : IDLE / RUN / FIN / DONE sequencer states
//   F3*          : func3 encodings of the eight M operations
//   OpcodeOp,
//   Func7MulDiv  : opcode/func7 pair that selects an M operation
//   Fwd*         : operand forwarding-select encodings
package muldiv_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StFin,
      StDone
   } state_e;

   localparam logic [6:0] OpcodeOp    = 7'b0110011;
   localparam logic [6:0] Func7MulDiv = 7'b0000001;

   localparam logic [2:0] F3Mul    = 3'd0;
   localparam logic [2:0] F3Mulh   = 3'd1;
   localparam logic [2:0] F3Mulhsu = 3'd2;
   localparam logic [2:0] F3Mulhu  = 3'd3;
   localparam logic [2:0] F3Div    = 3'd4;
   localparam logic [2:0] F3Divu   = 3'd5;
   localparam logic [2:0] F3Rem    = 3'd6;
   localparam logic [2:0] F3Remu   = 3'd7;

   localparam logic [1:0] FwdMem = 2'b01;
   localparam logic [1:0] FwdWb  = 2'b10;

   // MUL is listed as signed: its low half is identical either way.
   function automatic logic op1_is_signed(logic [2:0] f3);
      return (f3 == F3Mul) || (f3 == F3Mulh) || (f3 == F3Mulhsu) ||
             (f3 == F3Div) || (f3 == F3Rem);
   endfunction

   function automatic logic op2_is_signed(logic [2:0] f3);
      return (f3 == F3Mul) || (f3 == F3Mulh) || (f3 == F3Div) || (f3 == F3Rem);
   endfunction

endpackage

// File: rtl/muldiv_execute_unit_if.sv
// muldiv_execute_unit_if: EX-stage bundle between the pipeline and the M unit.
//   master : pipeline side (drives instruction, operands, forwarding, flush)
//   slave  : execute unit side (drives stall, result, writeback strobe)
interface muldiv_execute_unit_if #(
   parameter int unsigned XLEN = 32
);
   logic [6:0]      opcode;
   logic [6:0]      func7;
   logic [2:0]      func3;
   logic [XLEN-1:0] op1;
   logic [XLEN-1:0] op2;
   logic [1:0]      operand_a_forward_cntl;
   logic [1:0]      operand_b_forward_cntl;
   logic [XLEN-1:0] data_forward_mem;
   logic [XLEN-1:0] data_forward_wb;
   logic [4:0]      alu_rd;
   logic            pipeline_flush;
   logic            stall;
   logic [XLEN-1:0] result;
   logic            result_valid;
   logic [4:0]      wb_rd;
   logic            wb_reg_file;

   modport master (
      output opcode, func7, func3, op1, op2, operand_a_forward_cntl, operand_b_forward_cntl,
             data_forward_mem, data_forward_wb, alu_rd, pipeline_flush,
      input  stall, result, result_valid, wb_rd, wb_reg_file
   );

   modport slave (
      input  opcode, func7, func3, op1, op2, operand_a_forward_cntl, operand_b_forward_cntl,
             data_forward_mem, data_forward_wb, alu_rd, pipeline_flush,
      output stall, result, result_valid, wb_rd, wb_reg_file
   );
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: combinational BPC-bit iteration shared by multiply and divide.
//   is_div_i : 1 = restoring divide step, 0 = shift-add multiply step
//   hi_i/lo_i: multiply: partial product high / multiplier+product low
//              divide  : partial remainder / dividend shifting into quotient
//   b_i      : multiplicand or divisor magnitude
//   hi_o/lo_o: state after BPC iterations
module muldiv_step #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned BPC  = 1
) (
   input  logic            is_div_i,
   input  logic [XLEN-1:0] hi_i,
   input  logic [XLEN-1:0] lo_i,
   input  logic [XLEN-1:0] b_i,
   output logic [XLEN-1:0] hi_o,
   output logic [XLEN-1:0] lo_o
);

   logic [XLEN-1:0] hi_v;
   logic [XLEN-1:0] lo_v;
   logic [XLEN:0]   t_v;

   always_comb begin
      hi_v = hi_i;
      lo_v = lo_i;
      t_v  = '0;
      for (int i = 0; i < BPC; i++) begin
         if (is_div_i) begin
            // Partial remainder stays below the divisor, so XLEN+1 bits hold the shifted value.
            t_v  = {hi_v, lo_v[XLEN-1]};
            lo_v = {lo_v[XLEN-2:0], 1'b0};
            if (t_v >= {1'b0, b_i}) begin
               t_v     = t_v - {1'b0, b_i};
               lo_v[0] = 1'b1;
            end
            hi_v = t_v[XLEN-1:0];
         end else begin
            t_v  = {1'b0, hi_v} + (lo_v[0] ? {1'b0, b_i} : '0);
            lo_v = {t_v[0], lo_v[XLEN-1:1]};
            hi_v = t_v[XLEN:1];
         end
      end
      hi_o = hi_v;
      lo_o = lo_v;
   end

endmodule

// File: rtl/muldiv_execute_unit.sv
// muldiv_execute_unit: iterative RV32M/RV64M multiply/divide beside the EX ALU.
//   clk_i : clock
//   rst_i : synchronous active-high reset
//   bus   : slave side of muldiv_execute_unit_if (instruction, operands, forwarding,
//           flush in; stall, result, result_valid, wb_rd, wb_reg_file out)
// Operands are latched as magnitudes; RUN retires BPC bits per cycle for XLEN/BPC
// cycles, FIN applies sign correction, DONE strobes the result for one cycle.
module muldiv_execute_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned XLEN = 32,
   parameter int unsigned BPC  = 1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   muldiv_execute_unit_if.slave bus
);

   localparam int unsigned Iters = XLEN / BPC;
   localparam int unsigned CntW  = $clog2(Iters);

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [2:0]        func3_q, func3_d;
   logic [4:0]        rd_q, rd_d;
   logic              sign_a_q, sign_a_d;
   logic              sign_b_q, sign_b_d;
   logic [XLEN-1:0]   hi_q, hi_d;
   logic [XLEN-1:0]   lo_q, lo_d;
   logic [XLEN-1:0]   b_q, b_d;
   logic [XLEN-1:0]   result_q, result_d;

   logic [XLEN-1:0]   fwd_a, fwd_b, mag_a, mag_b, special_res;
   logic [XLEN-1:0]   step_hi, step_lo, quo_c, rem_c;
   logic [2*XLEN-1:0] prod_c;
   logic              is_m_op, accept, sa, sb, div_zero, div_ovf;

   always_comb begin
      case (bus.operand_a_forward_cntl)
         FwdMem:  fwd_a = bus.data_forward_mem;
         FwdWb:   fwd_a = bus.data_forward_wb;
         default: fwd_a = bus.op1;
      endcase
      case (bus.operand_b_forward_cntl)
         FwdMem:  fwd_b = bus.data_forward_mem;
         FwdWb:   fwd_b = bus.data_forward_wb;
         default: fwd_b = bus.op2;
      endcase
   end

   assign is_m_op = (bus.opcode == OpcodeOp) && (bus.func7 == Func7MulDiv);
   assign accept  = is_m_op && (state_q == StIdle) && !bus.pipeline_flush && !rst_i;

   assign sa    = op1_is_signed(bus.func3) && fwd_a[XLEN-1];
   assign sb    = op2_is_signed(bus.func3) && fwd_b[XLEN-1];
   assign mag_a = sa ? -fwd_a : fwd_a;
   assign mag_b = sb ? -fwd_b : fwd_b;

   // Only signed DIV/REM (func3[0]=0) can overflow.
   assign div_zero = bus.func3[2] && (fwd_b == '0);
   assign div_ovf  = bus.func3[2] && !bus.func3[0] && (fwd_b == '1) &&
                     (fwd_a == {1'b1, {(XLEN-1){1'b0}}});

   always_comb begin
      special_res = '0;
      if (div_zero) begin
         special_res = bus.func3[1] ? fwd_a : '1;
      end else if (div_ovf) begin
         special_res = bus.func3[1] ? '0 : fwd_a;
      end
   end

   muldiv_step #(
      .XLEN (XLEN),
      .BPC  (BPC)
   ) u_step (
      .is_div_i (func3_q[2]),
      .hi_i     (hi_q),
      .lo_i     (lo_q),
      .b_i      (b_q),
      .hi_o     (step_hi),
      .lo_o     (step_lo)
   );

   assign prod_c = (sign_a_q ^ sign_b_q) ? -{hi_q, lo_q} : {hi_q, lo_q};
   assign quo_c  = (sign_a_q ^ sign_b_q) ? -lo_q : lo_q;
   assign rem_c  = sign_a_q ? -hi_q : hi_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      func3_d  = func3_q;
      rd_d     = rd_q;
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      b_d      = b_q;
      result_d = result_q;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               func3_d  = bus.func3;
               rd_d     = bus.alu_rd;
               sign_a_d = sa;
               sign_b_d = sb;
               hi_d     = '0;
               lo_d     = mag_a;
               b_d      = mag_b;
               cnt_d    = '0;
               if (div_zero || div_ovf) begin
                  result_d = special_res;
                  state_d  = StDone;
               end else begin
                  state_d = StRun;
               end
            end
         end
         StRun: begin
            hi_d  = step_hi;
            lo_d  = step_lo;
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == CntW'(Iters - 1)) begin
               state_d = StFin;
            end
         end
         StFin: begin
            unique case (func3_q)
               F3Mul:                     result_d = prod_c[XLEN-1:0];
               F3Mulh, F3Mulhsu, F3Mulhu: result_d = prod_c[2*XLEN-1:XLEN];
               F3Div, F3Divu:             result_d = quo_c;
               F3Rem, F3Remu:             result_d = rem_c;
            endcase
            state_d = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
      endcase

      // A killed op never updates the visible result.
      if (bus.pipeline_flush) begin
         state_d  = StIdle;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         func3_q  <= '0;
         rd_q     <= '0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         b_q      <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         func3_q  <= func3_d;
         rd_q     <= rd_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         b_q      <= b_d;
         result_q <= result_d;
      end
   end

   assign bus.stall        = !bus.pipeline_flush &&
                             (accept || (state_q == StRun) || (state_q == StFin));
   assign bus.result       = result_q;
   assign bus.result_valid = (state_q == StDone);
   assign bus.wb_rd        = (state_q == StDone) ? rd_q : 5'd0;
   assign bus.wb_reg_file  = (state_q == StDone);

endmodule

// File: tb/tb_muldiv_execute_unit.sv
// tb_muldiv_execute_unit: self-checking bench for muldiv_execute_unit. Two instances
// (BPC=1 and BPC=4, XLEN=32) share the stimulus; sel routes the M opcode to one of them.
module tb_muldiv_execute_unit;

   localparam logic [31:0] Min32 = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [6:0]  opcode = 7'd0;
   logic [6:0]  func7 = 7'd0;
   logic [2:0]  func3 = 3'd0;
   logic [31:0] op1 = '0, op2 = '0, dmem = '0, dwb = '0;
   logic [1:0]  fa = 2'd0, fb = 2'd0;
   logic [4:0]  rd = 5'd0;
   logic        flush = 1'b0;
   int          sel = 1;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   muldiv_execute_unit_if #(.XLEN(32)) ifc1 ();
   muldiv_execute_unit_if #(.XLEN(32)) ifc4 ();

   assign ifc1.opcode = (sel == 1) ? opcode : 7'd0;
   assign ifc4.opcode = (sel == 4) ? opcode : 7'd0;
   assign ifc1.func7 = func7;
   assign ifc4.func7 = func7;
   assign ifc1.func3 = func3;
   assign ifc4.func3 = func3;
   assign ifc1.op1 = op1;
   assign ifc4.op1 = op1;
   assign ifc1.op2 = op2;
   assign ifc4.op2 = op2;
   assign ifc1.operand_a_forward_cntl = fa;
   assign ifc4.operand_a_forward_cntl = fa;
   assign ifc1.operand_b_forward_cntl = fb;
   assign ifc4.operand_b_forward_cntl = fb;
   assign ifc1.data_forward_mem = dmem;
   assign ifc4.data_forward_mem = dmem;
   assign ifc1.data_forward_wb = dwb;
   assign ifc4.data_forward_wb = dwb;
   assign ifc1.alu_rd = rd;
   assign ifc4.alu_rd = rd;
   assign ifc1.pipeline_flush = flush;
   assign ifc4.pipeline_flush = flush;

   muldiv_execute_unit #(.XLEN(32), .BPC(1)) u_dut1 (.clk_i(clk), .rst_i(rst), .bus(ifc1));
   muldiv_execute_unit #(.XLEN(32), .BPC(4)) u_dut4 (.clk_i(clk), .rst_i(rst), .bus(ifc4));

   // Reference: plain RV32M arithmetic.
   function automatic logic [31:0] ref_model(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
      longint      sa, sb, ub;
      logic [63:0] p;
      logic [31:0] r;
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      ub = longint'({32'd0, b});
      r  = '0;
      case (f3)
         3'd0: begin p = 64'(a) * 64'(b); r = p[31:0]; end
         3'd1: begin p = sa * sb; r = p[63:32]; end
         3'd2: begin p = sa * ub; r = p[63:32]; end
         3'd3: begin p = 64'(a) * 64'(b); r = p[63:32]; end
         3'd4: r = (b == 0) ? 32'hFFFF_FFFF : (a == Min32 && b == 32'hFFFF_FFFF) ? a :
                   32'(signed'(a) / signed'(b));
         3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: r = (b == 0) ? a : (a == Min32 && b == 32'hFFFF_FFFF) ? 32'd0 :
                   32'(signed'(a) % signed'(b));
         default: r = (b == 0) ? a : a % b;
      endcase
      return r;
   endfunction

   function automatic bit is_special(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
      return f3[2] && ((b == 0) || (!f3[0] && a == Min32 && b == 32'hFFFF_FFFF));
   endfunction

   task automatic sample(input int which, output logic st, output logic rv,
                         output logic [31:0] res, output logic [4:0] wrd, output logic wrf);
      if (which == 1) begin
         st = ifc1.stall; rv = ifc1.result_valid; res = ifc1.result;
         wrd = ifc1.wb_rd; wrf = ifc1.wb_reg_file;
      end else begin
         st = ifc4.stall; rv = ifc4.result_valid; res = ifc4.result;
         wrd = ifc4.wb_rd; wrf = ifc4.wb_reg_file;
      end
   endtask

   task automatic drive_op(input int which, input logic [2:0] f3, input logic [31:0] a_reg,
                           input logic [31:0] b_reg, input logic [1:0] fsa, input logic [1:0] fsb,
                           input logic [31:0] mem, input logic [31:0] wb, input logic [4:0] rdv);
      sel = which; opcode = 7'b0110011; func7 = 7'b0000001; func3 = f3;
      op1 = a_reg; op2 = b_reg; fa = fsa; fb = fsb; dmem = mem; dwb = wb; rd = rdv;
   endtask

   // Runs one op and checks latency, stall profile, result, wb_rd and return to idle.
   task automatic run_op(input string name, input int which, input logic [2:0] f3,
                         input logic [31:0] a_reg, input logic [31:0] b_reg,
                         input logic [1:0] fsa, input logic [1:0] fsb,
                         input logic [31:0] mem, input logic [31:0] wb, input logic [4:0] rdv);
      logic [31:0] a, b, exp_res, res;
      logic        st, rv, wrf, seen;
      logic [4:0]  wrd;
      int          lat, stall_err, k;
      a = (fsa == 2'b01) ? mem : (fsa == 2'b10) ? wb : a_reg;
      b = (fsb == 2'b01) ? mem : (fsb == 2'b10) ? wb : b_reg;
      exp_res = ref_model(f3, a, b);
      lat = is_special(f3, a, b) ? 1 : (32 / which) + 2;
      stall_err = 0;
      seen = 1'b0;
      @(negedge clk);
      drive_op(which, f3, a_reg, b_reg, fsa, fsb, mem, wb, rdv);
      for (k = 0; k <= 60; k++) begin
         if (k > 0) @(negedge clk);
         if (k == 1) begin
            // Operands and forwarding data must have been latched at accept.
            dmem = 32'd99; dwb = $urandom; op1 = $urandom; op2 = $urandom;
         end
         #1;
         sample(which, st, rv, res, wrd, wrf);
         if (st !== (k < lat)) stall_err++;
         if (rv === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      opcode = 7'd0;
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL %s timeout: no result_valid within 60 cycles, want cycle %0d", name, lat);
      end else begin
         total += 4;
         if (k != lat) begin
            bad++; $display("FAIL %s latency: got %0d want %0d", name, k, lat);
         end
         if (res !== exp_res) begin
            bad++; $display("FAIL %s result: got %h want %h", name, res, exp_res);
         end
         if (wrd !== rdv || wrf !== 1'b1) begin
            bad++; $display("FAIL %s wb: got rd=%0d wrf=%b want rd=%0d wrf=1", name, wrd, wrf, rdv);
         end
         if (stall_err != 0) begin
            bad++; $display("FAIL %s stall: got %0d bad cycles want 0", name, stall_err);
         end
         @(negedge clk); #1;
         sample(which, st, rv, res, wrd, wrf);
         if (st !== 1'b0 || rv !== 1'b0 || wrd !== 5'd0) begin
            bad++;
            $display("FAIL %s idle: got stall=%b valid=%b rd=%0d want 0 0 0", name, st, rv, wrd);
         end
      end
   endtask

   task automatic test_reset;
      logic [31:0] res;
      logic        st, rv, wrf;
      logic [4:0]  wrd;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      for (int w = 1; w <= 4; w += 3) begin
         #1;
         sample(w, st, rv, res, wrd, wrf);
         total++;
         if (st !== 1'b0 || rv !== 1'b0 || res !== 32'd0 || wrd !== 5'd0 || wrf !== 1'b0) begin
            bad++;
            $display("FAIL reset dut%0d: got stall=%b valid=%b res=%h rd=%0d wrf=%b want all 0",
                     w, st, rv, res, wrd, wrf);
         end
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_mul;
      run_op("mul_7x-3", 1, 3'd0, 32'd7, 32'hFFFF_FFFD, 2'd0, 2'd0, 0, 0, 5'd5);
      for (int w = 1; w <= 4; w += 3) begin
         run_op("mulhu_max", w, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd0, 2'd0, 0, 0, 5'd7);
         run_op("mulhsu_-1x2", w, 3'd2, 32'hFFFF_FFFF, 32'd2, 2'd0, 2'd0, 0, 0, 5'd9);
         run_op("mulh_neg", w, 3'd1, 32'h8000_0000, 32'h8000_0000, 2'd0, 2'd0, 0, 0, 5'd3);
      end
   endtask

   task automatic test_div;
      run_op("div_-7/2", 1, 3'd4, 32'hFFFF_FFF9, 32'd2, 2'd0, 2'd0, 0, 0, 5'd10);
      run_op("rem_-7%2", 1, 3'd6, 32'hFFFF_FFF9, 32'd2, 2'd0, 2'd0, 0, 0, 5'd11);
      run_op("divu_100/7", 1, 3'd5, 32'd100, 32'd7, 2'd0, 2'd0, 0, 0, 5'd12);
      run_op("remu_100%7", 4, 3'd7, 32'd100, 32'd7, 2'd0, 2'd0, 0, 0, 5'd13);
   endtask

   task automatic test_special;
      run_op("divu_by0", 1, 3'd5, 32'd100, 32'd0, 2'd0, 2'd0, 0, 0, 5'd14);
      run_op("rem_by0", 1, 3'd6, 32'd100, 32'd0, 2'd0, 2'd0, 0, 0, 5'd15);
      run_op("div_ovf", 1, 3'd4, Min32, 32'hFFFF_FFFF, 2'd0, 2'd0, 0, 0, 5'd16);
      run_op("rem_ovf", 4, 3'd6, Min32, 32'hFFFF_FFFF, 2'd0, 2'd0, 0, 0, 5'd17);
   endtask

   // Flushes a DIV on dut1 at cycle fc; the op must never produce result_valid.
   task automatic test_flush_at(input int fc);
      int seen_valid, early;
      early = 0; seen_valid = 0;
      @(negedge clk);
      drive_op(1, 3'd4, 32'd1000, 32'd3, 2'd0, 2'd0, 0, 0, 5'd21);
      for (int k = 0; k < fc; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         if (ifc1.stall !== 1'b1) early++;
      end
      @(negedge clk);
      flush = 1'b1;
      #1;
      total += 2;
      if (early != 0) begin
         bad++; $display("FAIL flush%0d pre_stall: got %0d low cycles want 0", fc, early);
      end
      if (ifc1.stall !== 1'b0) begin
         bad++; $display("FAIL flush%0d stall: got %b want 0", fc, ifc1.stall);
      end
      @(negedge clk);
      flush = 1'b0; opcode = 7'd0;
      #1;
      total++;
      if (ifc1.stall !== 1'b0 || ifc1.result_valid !== 1'b0) begin
         bad++;
         $display("FAIL flush%0d idle: got stall=%b valid=%b want 0 0", fc, ifc1.stall,
                  ifc1.result_valid);
      end
      for (int k = 0; k < 40; k++) begin
         @(negedge clk); #1;
         if (ifc1.result_valid === 1'b1) seen_valid++;
      end
      total++;
      if (seen_valid != 0) begin
         bad++; $display("FAIL flush%0d killed_valid: got %0d strobes want 0", fc, seen_valid);
      end
   endtask

   task automatic test_flush;
      test_flush_at(10);
      run_op("mul_after_flush", 1, 3'd0, 32'd12, 32'd11, 2'd0, 2'd0, 0, 0, 5'd22);
      test_flush_at(33);
   endtask

   task automatic test_forwarding;
      run_op("fwd_mem_a", 1, 3'd0, 32'd123, 32'd5, 2'b01, 2'b00, 32'd6, 32'd77, 5'd23);
      run_op("fwd_wb_b", 4, 3'd0, 32'd9, 32'd123, 2'b11, 2'b10, 32'd6, 32'd4, 5'd24);
   endtask

   function automatic logic [31:0] rand_operand();
      logic [31:0] pick [4];
      pick[0] = 32'd0; pick[1] = 32'd1; pick[2] = 32'hFFFF_FFFF; pick[3] = Min32;
      if ($urandom_range(3) == 0) return pick[$urandom_range(3)];
      if ($urandom_range(1) == 0) return 32'($urandom_range(1000));
      return $urandom;
   endfunction

   task automatic test_random;
      for (int i = 0; i < 40; i++) begin
         run_op("random", ($urandom_range(1) == 0) ? 1 : 4, 3'($urandom_range(7)),
                rand_operand(), rand_operand(), 2'($urandom_range(3)), 2'($urandom_range(3)),
                rand_operand(), rand_operand(), 5'($urandom_range(31)));
      end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_special();
      test_flush();
      test_forwarding();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
